// File: rtl/modulo_varredura_matriz_pkg.sv
// Shared definitions for the 5x7 LED matrix row scanner.
//   - FSM state encodings (IDLE/BLANK/SHOW) kept as plain 2-bit constants
//     so they stay bit-compatible with the legacy encoding.
//   - Matrix geometry (N_LINHAS rows, N_COLUNAS columns).
//   - LINHA_OFF: row-enable pattern with every row dark (rows are active-low).
//   - linha_ativa(): one-hot-low row-enable pattern for a row index.
package modulo_varredura_matriz_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam int unsigned N_LINHAS  = 7;
  localparam int unsigned N_COLUNAS = 5;

  localparam logic [N_LINHAS-1:0] LINHA_OFF = 7'b1111111;

  // Index of row 7, the last row of a frame.
  localparam logic [2:0] ULTIMA_LINHA = 3'd6;

  // Drives only row r low. An index beyond the last row shifts the single
  // one out of the vector, which leaves every row dark.
  function automatic logic [N_LINHAS-1:0] linha_ativa(input logic [2:0] r);
    logic [N_LINHAS-1:0] um;
    um          = 7'b0000001;
    linha_ativa = ~(um << r);
  endfunction

endpackage

// File: rtl/modulo_varredura_matriz_mux_linha_7x5.sv
// Combinational 7:1 selector of the five-bit column pattern for the row
// currently being scanned.
// Ports:
//   cl1_i..cl7_i  in  5  column patterns for rows 1..7
//   sel_i         in  3  row index, 0 = row 1
//   col_o         out 5  selected pattern (all-off for an out-of-range index)
module mux_linha_7x5
  import modulo_varredura_matriz_pkg::*;
(
  input  logic [N_COLUNAS-1:0] cl1_i,
  input  logic [N_COLUNAS-1:0] cl2_i,
  input  logic [N_COLUNAS-1:0] cl3_i,
  input  logic [N_COLUNAS-1:0] cl4_i,
  input  logic [N_COLUNAS-1:0] cl5_i,
  input  logic [N_COLUNAS-1:0] cl6_i,
  input  logic [N_COLUNAS-1:0] cl7_i,
  input  logic [2:0]           sel_i,
  output logic [N_COLUNAS-1:0] col_o
);

  always_comb begin
    col_o = '0;
    case (sel_i)
      3'd0:    col_o = cl1_i;
      3'd1:    col_o = cl2_i;
      3'd2:    col_o = cl3_i;
      3'd3:    col_o = cl4_i;
      3'd4:    col_o = cl5_i;
      3'd5:    col_o = cl6_i;
      3'd6:    col_o = cl7_i;
      default: col_o = '0;
    endcase
  end

endmodule

// File: rtl/modulo_varredura_matriz.sv
// Row-scanning driver for the 5x7 LED matrix. Sequences the seven rows with
// an all-dark blanking gap before each row and drives the column lines from
// the per-row presets. Owns the registered symbol code HH, which is only
// reloaded when a scan starts or at a frame boundary, so a symbol never
// changes partway through a frame.
// Parameters:
//   DWELL      clock cycles each row is lit (>= 1)
//   BLANK_CYC  clock cycles of all-off blanking before each row (>= 1)
// Ports:
//   clk         in  1  system clock, rising edge
//   rst_n       in  1  synchronous active-low reset
//   en          in  1  scan enable; low forces the matrix dark
//   HH_in       in  2  requested symbol code
//   HH          out 2  registered symbol code fed to the preset modules
//   cl1..cl7    in  5  column patterns for rows 1..7, 1 = LED on
//   linha       out 7  row enables, active-low, linha[0] = row 1
//   coluna      out 5  column drive, active-high
//   frame_done  out 1  one-cycle pulse in the first blanking cycle after row 7
module modulo_varredura_matriz
  import modulo_varredura_matriz_pkg::*;
#(
  parameter int unsigned DWELL     = 1000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           HH_in,
  output logic [1:0]           HH,
  input  logic [N_COLUNAS-1:0] cl1,
  input  logic [N_COLUNAS-1:0] cl2,
  input  logic [N_COLUNAS-1:0] cl3,
  input  logic [N_COLUNAS-1:0] cl4,
  input  logic [N_COLUNAS-1:0] cl5,
  input  logic [N_COLUNAS-1:0] cl6,
  input  logic [N_COLUNAS-1:0] cl7,
  output logic [N_LINHAS-1:0]  linha,
  output logic [N_COLUNAS-1:0] coluna,
  output logic                 frame_done
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  // Keeps the counter at least one bit wide when both periods are one cycle.
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_FIM = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_FIM = CNT_W'(BLANK_CYC - 1);

  logic [1:0]           state_q,  state_d;
  logic [2:0]           r_q,      r_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [1:0]           hh_q,     hh_d;
  logic [N_LINHAS-1:0]  linha_q,  linha_d;
  logic [N_COLUNAS-1:0] coluna_q, coluna_d;
  logic                 fd_q,     fd_d;

  logic [N_COLUNAS-1:0] col_sel;

  mux_linha_7x5 u_mux_linha (
    .cl1_i (cl1),
    .cl2_i (cl2),
    .cl3_i (cl3),
    .cl4_i (cl4),
    .cl5_i (cl5),
    .cl6_i (cl6),
    .cl7_i (cl7),
    .sel_i (r_q),
    .col_o (col_sel)
  );

  // Output registers follow the state held during the current cycle, so each
  // row is lit for exactly the DWELL cycles spent in SHOW, one cycle behind
  // the state register. Dropping en overrides this and goes dark at once.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    hh_d     = hh_q;
    fd_d     = 1'b0;
    linha_d  = LINHA_OFF;
    coluna_d = '0;

    if (!en) begin
      state_d = IDLE;
      r_d     = '0;
      cnt_d   = '0;
    end else begin
      if (state_q == SHOW) begin
        linha_d  = linha_ativa(r_q);
        coluna_d = col_sel;
      end

      case (state_q)
        IDLE: begin
          hh_d    = HH_in;
          r_d     = '0;
          cnt_d   = '0;
          state_d = BLANK;
        end
        BLANK: begin
          if (cnt_q == BLANK_FIM) begin
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_FIM) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (r_q == ULTIMA_LINHA) begin
              // Frame boundary: the only point where a new symbol is taken.
              r_d  = '0;
              fd_d = 1'b1;
              hh_d = HH_in;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          r_d     = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      cnt_q    <= '0;
      hh_q     <= '0;
      linha_q  <= LINHA_OFF;
      coluna_q <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      hh_q     <= hh_d;
      linha_q  <= linha_d;
      coluna_q <= coluna_d;
      fd_q     <= fd_d;
    end
  end

  assign HH         = hh_q;
  assign linha      = linha_q;
  assign coluna     = coluna_q;
  assign frame_done = fd_q;

endmodule
